// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory request into one or two word-aligned memory beats,
// handling misaligned splits, lane positioning and load sign/zero extension.
// iInstructionType: 1 = LOAD, 2 = STORE, others ignored.
// iMemoryInstructionType (funct3 style): 0 B, 1 H, 2 W, 4 BU, 5 HU; any other value is a word.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic [1:0]            iInstructionType,
  input  logic [2:0]            iMemoryInstructionType,
  input  logic [31:0]           iAddress,
  input  logic [DATA_WIDTH-1:0] iStoreData,
  output logic                  oRespValid,
  output logic [DATA_WIDTH-1:0] oLoadData,
  output logic                  oBusy,
  output logic                  oMemReqValid,
  input  logic                  iMemReqReady,
  output logic                  oMemWriteEn,
  output logic [31:0]           oMemAddr,
  output logic [3:0]            oMemByteEn,
  output logic [DATA_WIDTH-1:0] oMemWData,
  input  logic                  iMemRespValid,
  input  logic [DATA_WIDTH-1:0] iMemRData
);

  localparam logic [1:0] InstrLoad  = 2'd1;
  localparam logic [1:0] InstrStore = 2'd2;

  typedef enum logic [2:0] {StIdle, StIssue1, StWait1, StIssue2, StWait2, StDone} state_e;

  state_e                  state_q;
  logic                    is_store_q;
  logic [2:0]              sub_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_hi_q;
  logic [3:0]              be_hi_q;
  logic [DATA_WIDTH-1:0]   r1_q;
  logic [DATA_WIDTH-1:0]   load_data_q;
  logic                    mem_valid_q;
  logic                    mem_we_q;
  logic [31:0]             mem_addr_q;
  logic [3:0]              mem_be_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    resp_valid_q;

  logic [7:0]              in_mask;
  logic [2*DATA_WIDTH-1:0] in_shift;
  logic                    is_mem_op;
  logic                    split;

  // Byte-lane mask across two consecutive words; size depends only on the low subtype bits.
  function automatic logic [7:0] lane_mask(input logic [2:0] sub, input logic [1:0] off);
    logic [7:0] base;
    unique case (sub[1:0])
      2'd0:    base = 8'b0000_0001;
      2'd1:    base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2*DATA_WIDTH-1:0] raw,
                                                     input logic [1:0] off,
                                                     input logic [2:0] sub);
    logic [DATA_WIDTH-1:0] l;
    logic [DATA_WIDTH-1:0] res;
    l = DATA_WIDTH'(raw >> {off, 3'b000});
    unique case (sub)
      3'd0:    res = {{(DATA_WIDTH-8){l[7]}}, l[7:0]};
      3'd4:    res = {{(DATA_WIDTH-8){1'b0}}, l[7:0]};
      3'd1:    res = {{(DATA_WIDTH-16){l[15]}}, l[15:0]};
      3'd5:    res = {{(DATA_WIDTH-16){1'b0}}, l[15:0]};
      default: res = l;
    endcase
    return res;
  endfunction

  always_comb begin
    in_mask   = lane_mask(iMemoryInstructionType, iAddress[1:0]);
    in_shift  = {{DATA_WIDTH{1'b0}}, iStoreData} << {iAddress[1:0], 3'b000};
    is_mem_op = (iInstructionType == InstrLoad) || (iInstructionType == InstrStore);
    split     = |be_hi_q;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      sub_q        <= '0;
      addr_q       <= '0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
      r1_q         <= '0;
      load_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iReqValid && is_mem_op) begin
            is_store_q  <= (iInstructionType == InstrStore);
            sub_q       <= iMemoryInstructionType;
            addr_q      <= iAddress;
            wdata_hi_q  <= in_shift[2*DATA_WIDTH-1:DATA_WIDTH];
            be_hi_q     <= in_mask[7:4];
            mem_valid_q <= 1'b1;
            mem_we_q    <= (iInstructionType == InstrStore);
            mem_addr_q  <= {iAddress[31:2], 2'b00};
            mem_be_q    <= in_mask[3:0];
            mem_wdata_q <= in_shift[DATA_WIDTH-1:0];
            state_q     <= StIssue1;
          end
        end
        StIssue1, StIssue2: begin
          if (iMemReqReady) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            state_q     <= (state_q == StIssue1) ? StWait1 : StWait2;
          end
        end
        StWait1: begin
          if (iMemRespValid) begin
            r1_q <= iMemRData;
            if (split) begin
              mem_valid_q <= 1'b1;
              mem_we_q    <= is_store_q;
              mem_addr_q  <= {addr_q[31:2] + 30'd1, 2'b00};
              mem_be_q    <= be_hi_q;
              mem_wdata_q <= wdata_hi_q;
              state_q     <= StIssue2;
            end else begin
              if (!is_store_q) begin
                load_data_q <= load_ext({{DATA_WIDTH{1'b0}}, iMemRData}, addr_q[1:0], sub_q);
              end
              state_q <= StDone;
            end
          end
        end
        StWait2: begin
          if (iMemRespValid) begin
            if (!is_store_q) begin
              load_data_q <= load_ext({iMemRData, r1_q}, addr_q[1:0], sub_q);
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          resp_valid_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oReqReady    = (state_q == StIdle) && iRstN;
  assign oBusy        = (state_q != StIdle);
  assign oRespValid   = resp_valid_q;
  assign oLoadData    = load_data_q;
  assign oMemReqValid = mem_valid_q;
  assign oMemWriteEn  = mem_we_q;
  assign oMemAddr     = mem_addr_q;
  assign oMemByteEn   = mem_be_q;
  assign oMemWData    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned/misaligned loads and stores, stalls and reset abort.
module tb_load_store_unit;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  itype;
  logic [2:0]  isub;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        busy;
  logic        mreq_valid;
  logic        mreq_ready;
  logic        mwe;
  logic [31:0] maddr;
  logic [3:0]  mbe;
  logic [31:0] mwdata;
  logic        mresp_valid;
  logic [31:0] mrdata;

  int vectors;
  int miscompares;

  localparam logic [1:0] TLoad  = 2'd1;
  localparam logic [1:0] TStore = 2'd2;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  localparam logic [2:0] SBU = 3'd4;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .iClk                  (clk),
    .iRstN                 (rstn),
    .iReqValid             (req_valid),
    .oReqReady             (req_ready),
    .iInstructionType      (itype),
    .iMemoryInstructionType(isub),
    .iAddress              (addr),
    .iStoreData            (sdata),
    .oRespValid            (resp_valid),
    .oLoadData             (load_data),
    .oBusy                 (busy),
    .oMemReqValid          (mreq_valid),
    .iMemReqReady          (mreq_ready),
    .oMemWriteEn           (mwe),
    .oMemAddr              (maddr),
    .oMemByteEn            (mbe),
    .oMemWData             (mwdata),
    .iMemRespValid         (mresp_valid),
    .iMemRData             (mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] t, input logic [2:0] s, input logic [31:0] a,
                     input logic [31:0] d);
    req_valid = 1'b1;
    itype     = t;
    isub      = s;
    addr      = a;
    sdata     = d;
    tick();
    req_valid = 1'b0;
    itype     = 2'd0;
    addr      = 32'h0;
    sdata     = 32'h0;
  endtask

  // Handshake edge, then the response sampled on the following edge.
  task automatic mem_beat(input logic [31:0] rd);
    tick();
    chk("wait_no_req", {31'b0, mreq_valid}, 32'd0);
    mresp_valid = 1'b1;
    mrdata      = rd;
    tick();
    mresp_valid = 1'b0;
    mrdata      = 32'h0;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic we);
    chk({tag, "_valid"}, {31'b0, mreq_valid}, 32'd1);
    chk({tag, "_addr"}, maddr, a);
    chk({tag, "_be"}, {28'b0, mbe}, {28'b0, be});
    chk({tag, "_wdata"}, mwdata, wd);
    chk({tag, "_we"}, {31'b0, mwe}, {31'b0, we});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    req_valid   = 1'b0;
    itype       = 2'd0;
    isub        = 3'd0;
    addr        = 32'h0;
    sdata       = 32'h0;
    mreq_ready  = 1'b1;
    mresp_valid = 1'b0;
    mrdata      = 32'h0;

    tick();
    tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mreq", {31'b0, mreq_valid}, 32'd0);
    chk("rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_maddr", maddr, 32'h0);
    chk("rst_mbe", {28'b0, mbe}, 32'h0);
    chk("rst_mwdata", mwdata, 32'h0);
    chk("rst_mwe", {31'b0, mwe}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rel_ready", {31'b0, req_ready}, 32'd1);

    // Unrecognised types are ignored.
    req(2'd0, SW, 32'h100, 32'h1);
    chk("ign0_busy", {31'b0, busy}, 32'd0);
    req(2'd3, SW, 32'h100, 32'h1);
    chk("ign3_busy", {31'b0, busy}, 32'd0);
    chk("ign_ready", {31'b0, req_ready}, 32'd1);

    // SW aligned, single beat.
    req(TStore, SW, 32'h0001_0004, 32'hDEAD_BEEF);
    chk_beat("sw", 32'h0001_0004, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    chk("sw_busy", {31'b0, busy}, 32'd1);
    chk("sw_ready", {31'b0, req_ready}, 32'd0);
    mem_beat(32'h0);
    chk("sw_done_resp", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("sw_resp", {31'b0, resp_valid}, 32'd1);
    chk("sw_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("sw_ldata_kept", load_data, 32'h0);
    tick();
    chk("sw_resp_pulse", {31'b0, resp_valid}, 32'd0);

    // LB / LBU at the top byte.
    req(TLoad, SB, 32'h0001_0007, 32'h0);
    chk_beat("lb", 32'h0001_0004, 4'b1000, 32'h0, 1'b0);
    mem_beat(32'h80FF_FFFF);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    tick();
    chk("lb_resp", {31'b0, resp_valid}, 32'd1);
    req(TLoad, SBU, 32'h0001_0007, 32'h0);
    mem_beat(32'h80FF_FFFF);
    chk("lbu_data", load_data, 32'h0000_0080);

    // LW split across two words.
    tick();
    req(TLoad, SW, 32'h0001_0002, 32'h0);
    chk_beat("lw1", 32'h0001_0000, 4'b1100, 32'h0, 1'b0);
    mem_beat(32'hAABB_CCDD);
    chk("lw_mid_resp", {31'b0, resp_valid}, 32'd0);
    chk("lw_mid_ldata", load_data, 32'h0000_0080);
    chk_beat("lw2", 32'h0001_0004, 4'b0011, 32'h0, 1'b0);
    mem_beat(32'h1122_3344);
    chk("lw_data", load_data, 32'h3344_AABB);
    chk("lw_done_resp", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("lw_resp", {31'b0, resp_valid}, 32'd1);

    // SH split with a five-cycle memory stall on beat 1.
    mreq_ready = 1'b0;
    req(TStore, SH, 32'h0001_0003, 32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      chk_beat("sh_stall", 32'h0001_0000, 4'b1000, 32'h3400_0000, 1'b1);
      chk("sh_stall_ready", {31'b0, req_ready}, 32'd0);
      tick();
    end
    mreq_ready = 1'b1;
    chk_beat("sh1", 32'h0001_0000, 4'b1000, 32'h3400_0000, 1'b1);
    mem_beat(32'h0);
    chk_beat("sh2", 32'h0001_0004, 4'b0001, 32'h0000_0012, 1'b1);
    mem_beat(32'h0);
    chk("sh_ldata_kept", load_data, 32'h3344_AABB);
    tick();
    chk("sh_resp", {31'b0, resp_valid}, 32'd1);

    // Reset in WAIT1, then a late response.
    req(TLoad, SW, 32'h0000_1000, 32'h0);
    tick();
    chk("abort_in_wait", {31'b0, mreq_valid}, 32'd0);
    rstn = 1'b0;
    tick();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd0);
    chk("abort_ldata", load_data, 32'h0);
    rstn        = 1'b1;
    mresp_valid = 1'b1;
    mrdata      = 32'h1234_5678;
    tick();
    mresp_valid = 1'b0;
    chk("late_resp", {31'b0, resp_valid}, 32'd0);
    chk("late_busy", {31'b0, busy}, 32'd0);
    chk("late_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("late_resp2", {31'b0, resp_valid}, 32'd0);

    // LW wrapping the top of the address space.
    req(TLoad, SW, 32'hFFFF_FFFE, 32'h0);
    chk_beat("wrap1", 32'hFFFF_FFFC, 4'b1100, 32'h0, 1'b0);
    mem_beat(32'h5566_7788);
    chk_beat("wrap2", 32'h0000_0000, 4'b0011, 32'h0, 1'b0);
    mem_beat(32'h99AA_BBCC);
    chk("wrap_data", load_data, 32'hBBCC_5566);
    tick();
    chk("wrap_resp", {31'b0, resp_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
